// File: rtl/word_skew_feeder.sv
// word_skew_feeder: reads K words from the input global buffer and feeds them to the pe_array as 8 time-skewed 16-bit lanes
//   Ports: clk_i/rst_ni (async active-low) clock and reset; start_i/base_addr_i/len_i transfer request;
//   busy_o/done_o status; rd_en_o/rd_addr_o/rd_data_i global buffer read port (1-cycle latency);
//   word_o skewed operand word (lane k delayed k cycles); clr_o/we_o pe_array control pulses aligned to lane 0.
//   Optional FEEDER_PERF_EN adds busy_cycles_o, a saturating count of busy cycles of the latest transfer.
module word_skew_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10,
    parameter int WORD_WIDTH = LANES * DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [WORD_WIDTH-1:0] rd_data_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  clr_o,
    output logic                  we_o
`ifdef FEEDER_PERF_EN
    ,
    output logic [31:0]           busy_cycles_o
`endif
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    logic [1:0]           state;
    logic [LEN_WIDTH-1:0] idx;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 rd_vld;
    logic                 first_d;
    logic                 last_d;
    logic                 last_dd;
    logic                 last_rd;
    assign rd_en_o = state == READ;
    assign busy_o  = state != IDLE;
    assign done_o  = state == DONE;
    assign last_rd = idx == len_q - LEN_WIDTH'(1);
    // idx counts issued reads in READ and drain cycles in DRAIN; DRAIN ends when idx reaches LANES,
    // covering read latency + lane-0 register + LANES-1 skew stages. A zero-length transfer enters
    // DRAIN already at its final count so done_o lands two cycles after start_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            idx       <= '0;
            len_q     <= '0;
            rd_addr_o <= '0;
            rd_vld    <= 1'b0;
            first_d   <= 1'b0;
            last_d    <= 1'b0;
            last_dd   <= 1'b0;
            clr_o     <= 1'b0;
            we_o      <= 1'b0;
        end else begin
            rd_vld  <= rd_en_o;
            first_d <= rd_en_o && idx == '0;
            last_d  <= rd_en_o && last_rd;
            last_dd <= last_d;
            clr_o   <= first_d;
            we_o    <= last_dd;
            case (state)
                IDLE: if (start_i) begin
                    len_q     <= len_i;
                    rd_addr_o <= base_addr_i;
                    idx       <= len_i == '0 ? LEN_WIDTH'(LANES) : '0;
                    state     <= len_i == '0 ? DRAIN : READ;
                end
                READ: begin
                    rd_addr_o <= rd_addr_o + ADDR_WIDTH'(1);
                    idx       <= last_rd ? '0 : idx + LEN_WIDTH'(1);
                    state     <= last_rd ? DRAIN : READ;
                end
                DRAIN: begin
                    idx   <= idx + LEN_WIDTH'(1);
                    state <= idx == LEN_WIDTH'(LANES) ? DONE : DRAIN;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Lane k is a (k+1)-deep shift chain. Data enters zeroed whenever no read returned, so every
    // non-valid slot travels down the chain as a zero bubble.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] sr [k+1];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int j = 0; j <= k; j++) sr[j] <= '0;
            end else begin
                sr[0] <= rd_vld ? rd_data_i[k*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int j = 1; j <= k; j++) sr[j] <= sr[j-1];
            end
        end
        assign word_o[k*DATA_WIDTH +: DATA_WIDTH] = sr[k];
    end
`ifdef FEEDER_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_cycles_o <= '0;
        else if (state == IDLE && start_i) busy_cycles_o <= '0;
        else if (busy_o && busy_cycles_o != '1) busy_cycles_o <= busy_cycles_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_word_skew_feeder.sv
// tb_word_skew_feeder: directed vector bench for word_skew_feeder
module tb_word_skew_feeder;
    localparam int AW = 10;
    localparam int LW = 10;
    localparam int WW = 128;
    typedef struct {
        logic [AW-1:0] base;
        int            len;
        logic [3:0]    tag;
        int            reads;
        int            clr_n;
        int            we_n;
        int            done_n;
        int            busy;
    } vec_t;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, rd_en, clr, we;
    logic [AW-1:0] rd_addr;
    logic [WW-1:0] rd_data = '0;
    logic [WW-1:0] word;
`ifdef FEEDER_PERF_EN
    logic [31:0]   busy_cycles;
`endif
    logic [WW-1:0] mem [1024];
    int errors = 0;
    int checks = 0;
    int n_rd, addr_err, clr_n, clr_cnt, we_n, we_cnt, done_n, done_cnt, busy_cnt, lane_err;
    vec_t v [6];

    always #5 clk = ~clk;

    always_ff @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : {8{16'hBEEF}};

    word_skew_feeder dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base), .len_i(len),
        .busy_o(busy), .done_o(done), .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .word_o(word), .clr_o(clr), .we_o(we)
`ifdef FEEDER_PERF_EN
        , .busy_cycles_o(busy_cycles)
`endif
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] mk(input int i, input logic [3:0] tag);
        logic [WW-1:0] w;
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = {tag, 12'(i * 16 + k)};
        return w;
    endfunction

    // lane j carries word i's lane j at relative cycle i+j+3 (read issued at cycle i+1), else zero
    function automatic logic [WW-1:0] exp_word(input int n, input int len_w, input logic [3:0] tag);
        logic [WW-1:0] w, src;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            int i;
            i = n - 3 - j;
            if (i >= 0 && i < len_w) begin
                src = mk(i, tag);
                w[j*16 +: 16] = src[j*16 +: 16];
            end
        end
        return w;
    endfunction

    // cycle n = number of rising edges since the one that sampled start_i
    task automatic run(input logic [AW-1:0] b, input int k, input logic [3:0] tag, input int inj_n);
        for (int i = 0; i < k; i++) mem[10'(b + i)] = mk(i, tag);
        n_rd = 0; addr_err = 0; clr_n = 0; clr_cnt = 0; we_n = 0; we_cnt = 0;
        done_n = 0; done_cnt = 0; busy_cnt = 0; lane_err = 0;
        @(negedge clk);
        base = b; len = LW'(k); start = 1'b1;
        @(negedge clk);
        start = 1'b0; base = 10'h155; len = LW'(7);
        for (int n = 1; n <= k + 20; n++) begin
            if (rd_en) begin
                if (rd_addr !== 10'(b + n_rd)) addr_err++;
                n_rd++;
            end
            if (clr) begin clr_cnt++; if (clr_n == 0) clr_n = n; end
            if (we) begin we_cnt++; if (we_n == 0) we_n = n; end
            if (done) begin done_cnt++; if (done_n == 0) done_n = n; end
            if (busy) busy_cnt++;
            if (word !== exp_word(n, k, tag)) lane_err++;
            start = (n == inj_n);
            if (n == inj_n) begin base = 10'h000; len = LW'(1); end
            @(negedge clk);
        end
    endtask

    task automatic check_run(input string nm, input vec_t e);
        check({nm, " reads"}, n_rd, e.reads);
        check({nm, " addr_seq_err"}, addr_err, 0);
        check({nm, " clr_cycle"}, clr_n, e.clr_n);
        check({nm, " clr_pulses"}, clr_cnt, e.len > 0 ? 1 : 0);
        check({nm, " we_cycle"}, we_n, e.we_n);
        check({nm, " we_pulses"}, we_cnt, e.len > 0 ? 1 : 0);
        check({nm, " done_cycle"}, done_n, e.done_n);
        check({nm, " done_pulses"}, done_cnt, 1);
        check({nm, " busy_cycles"}, busy_cnt, e.busy);
        check({nm, " lane_err"}, lane_err, 0);
`ifdef FEEDER_PERF_EN
        check({nm, " perf_count"}, busy_cycles, e.busy);
`endif
    endtask

    initial begin
        vec_t e;
        int dn;
        v[0] = '{10'h010, 4, 4'h0, 4, 3, 7, 14, 14};
        v[1] = '{10'h3FE, 4, 4'h1, 4, 3, 7, 14, 14};
        v[2] = '{10'h055, 1, 4'h2, 1, 3, 4, 11, 11};
        v[3] = '{10'h123, 0, 4'h3, 0, 0, 0, 2, 2};
        v[4] = '{10'h3FF, 3, 4'h4, 3, 3, 6, 13, 13};
        v[5] = '{10'h200, 9, 4'h5, 9, 3, 12, 19, 19};
        for (int i = 0; i < 1024; i++) mem[i] = {8{16'hDEAD}};
        repeat (2) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst rd_en", rd_en, 0);
        check("rst rd_addr", rd_addr, 0);
        check("rst clr", clr, 0);
        check("rst we", we, 0);
        check("rst word_nonzero", word != '0, 0);
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            run(v[t].base, v[t].len, v[t].tag, 0);
            check_run($sformatf("vec%0d", t), v[t]);
        end
        // second start in the middle of READ must be ignored
        run(10'h020, 6, 4'h6, 3);
        check("inj reads", n_rd, 6);
        check("inj addr_seq_err", addr_err, 0);
        check("inj done_cycle", done_n, 16);
        check("inj done_pulses", done_cnt, 1);
        check("inj lane_err", lane_err, 0);
        // reset in DRAIN aborts the transfer
        for (int i = 0; i < 2; i++) mem[10'(10'h040 + i)] = mk(i, 4'h7);
        @(negedge clk);
        base = 10'h040; len = LW'(2); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst word_active", word != '0, 1);
        rst_n = 1'b0;
        #1;
        check("rst_drain word_nonzero", word != '0, 0);
        check("rst_drain busy", busy, 0);
        check("rst_drain rd_en", rd_en, 0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("rst_drain done_pulses", dn, 0);
        e = '{10'h040, 2, 4'h8, 2, 3, 5, 12, 12};
        run(e.base, e.len, e.tag, 0);
        check_run("after_rst", e);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
